// File: rtl/booth_mul_iter.sv
// Iterative Booth multiplier with a parameterised radix (2^RADIX_LOG2) and signed/unsigned mode.
// It takes one operation at a time and returns it after a fixed N_DIG+2 cycle latency.
module booth_mul_iter #(
    parameter int unsigned WIDTH      = 52,
    parameter int unsigned RADIX_LOG2 = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 in_valid_i,
    output logic                 in_ready_o,
    input  logic [WIDTH-1:0]     a_i,
    input  logic [WIDTH-1:0]     b_i,
    input  logic                 signed_i,
    input  logic                 flush_i,
    output logic                 out_valid_o,
    input  logic                 out_ready_i,
    output logic [2*WIDTH-1:0]   product_o,
    output logic                 busy_o
);
    localparam int unsigned R     = RADIX_LOG2;
    localparam int unsigned N_DIG = (WIDTH + R) / R;
    localparam int unsigned CNT_W = $clog2(N_DIG + 1);
    localparam int unsigned AX_W  = WIDTH + 1;
    localparam int unsigned PP_W  = WIDTH + R;
    localparam int unsigned ACC_W = 2 * WIDTH + R + 2;
    localparam int unsigned BX_W  = N_DIG * R + 1;
    localparam logic [3:0]  HALF  = 4'(2 ** (R - 1));

    if (WIDTH < 4 || RADIX_LOG2 < 2 || RADIX_LOG2 > 4) begin : g_param_check
        $error("booth_mul_iter: illegal WIDTH or RADIX_LOG2");
    end

    typedef enum logic [1:0] {StIdle, StPrecomp, StMul, StDone} state_e;

    state_e           state_q, state_d;
    logic [AX_W-1:0]  ax_q, ax_d;
    logic [BX_W-1:0]  bx_q, bx_d;
    logic [PP_W-1:0]  m3_q, m3_d, m5_q, m5_d, m7_q, m7_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [PP_W-1:0]  axe, pp;
    logic [R:0]       dig;
    logic [3:0]       lo, mag;
    logic             neg;
    logic [ACC_W-1:0] ppx, term;
    logic [31:0]      sh;
    logic             unused_acc;

    // bx_q is shifted right by R each MUL cycle, so the current digit always sits at [R:0]
    always_comb begin
        dig = bx_q[R:0];
        lo  = 4'(dig[R-1:1]) + 4'(dig[0]);
        if (dig[R]) begin
            mag = HALF - lo;
            neg = (lo != HALF);
        end else begin
            mag = lo;
            neg = 1'b0;
        end
    end

    always_comb begin
        axe = {{(PP_W - AX_W){ax_q[AX_W-1]}}, ax_q};
        pp  = '0;
        case (mag)
            4'd1:    pp = axe;
            4'd2:    pp = axe << 1;
            4'd3:    pp = m3_q;
            4'd4:    pp = axe << 2;
            4'd5:    pp = m5_q;
            4'd6:    pp = m3_q << 1;
            4'd7:    pp = m7_q;
            4'd8:    pp = axe << 3;
            default: pp = '0;
        endcase
        ppx  = {{(ACC_W - PP_W){pp[PP_W-1]}}, pp};
        term = neg ? ~ppx : ppx;
        sh   = 32'(cnt_q) * R;
    end

    always_comb begin
        state_d = state_q;
        ax_d    = ax_q;
        bx_d    = bx_q;
        m3_d    = m3_q;
        m5_d    = m5_q;
        m7_d    = m7_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (in_valid_i) begin
                    ax_d    = {signed_i & a_i[WIDTH-1], a_i};
                    bx_d    = {{(BX_W - AX_W){signed_i & b_i[WIDTH-1]}}, b_i, 1'b0};
                    state_d = StPrecomp;
                end
            end
            StPrecomp: begin
                m3_d    = (R >= 3) ? axe + (axe << 1) : '0;
                m5_d    = (R == 4) ? axe + (axe << 2) : '0;
                m7_d    = (R == 4) ? (axe << 3) - axe : '0;
                acc_d   = '0;
                cnt_d   = '0;
                state_d = StMul;
            end
            StMul: begin
                // Negation is ~pp plus a carry-in placed at the same weight
                acc_d = acc_q + (term << sh) + (ACC_W'(neg) << sh);
                bx_d  = $signed(bx_q) >>> R;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(N_DIG - 1)) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                if (out_ready_i) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
        if (flush_i) begin
            state_d = StIdle;
            acc_d   = '0;
            cnt_d   = '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StIdle;
            ax_q    <= '0;
            bx_q    <= '0;
            m3_q    <= '0;
            m5_q    <= '0;
            m7_q    <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ax_q    <= ax_d;
            bx_q    <= bx_d;
            m3_q    <= m3_d;
            m5_q    <= m5_d;
            m7_q    <= m7_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
        end
    end

    assign in_ready_o  = (state_q == StIdle);
    assign busy_o      = (state_q == StPrecomp) || (state_q == StMul);
    assign out_valid_o = (state_q == StDone);
    assign product_o   = out_valid_o ? acc_q[2*WIDTH-1:0] : '0;
    // Headroom bits only guard against intermediate overflow
    assign unused_acc  = ^acc_q[ACC_W-1:2*WIDTH];

endmodule

// File: tb/tb_booth_mul_iter.sv
// Scoreboard bench: directed tests on a 52-bit radix-16 unit plus random sweeps over
// several WIDTH/RADIX_LOG2 configurations with output stalls and mid-operation resets.
module tb_booth_mul_iter;
    localparam int unsigned MW   = 52;
    localparam int unsigned MND  = 14;
    localparam int unsigned MLAT = 16;
    localparam int unsigned NCFG = 9;
    localparam int unsigned NOPS = 150;
    localparam int unsigned CFG_W [NCFG] = '{8, 8, 8, 52, 52, 64, 64, 64, 52};
    localparam int unsigned CFG_R [NCFG] = '{2, 3, 4, 2, 3, 2, 3, 4, 4};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;
    bit          sw_done [NCFG];

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference product: extend both operands to 128 bits, multiply, keep 2*w bits
    function automatic logic [127:0] model(input logic [63:0] a, input logic [63:0] b,
                                           input int unsigned w, input logic s);
        logic [127:0] m, m2, ae, be;
        m  = (128'(1) << w) - 128'(1);
        m2 = (w >= 64) ? '1 : ((128'(1) << (2 * w)) - 128'(1));
        ae = {64'd0, a} & m;
        be = {64'd0, b} & m;
        if (s && ae[w-1]) ae = ae | ~m;
        if (s && be[w-1]) be = be | ~m;
        return (ae * be) & m2;
    endfunction

    function automatic logic [63:0] rnd_op(input int unsigned w);
        logic [63:0] r, m;
        m = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
        r = {$urandom(), $urandom()};
        case ($urandom_range(0, 7))
            0: r = '1;
            1: r = 64'd1 << (w - 1);
            2: r = '0;
            3: r = (64'd1 << (w - 1)) - 64'd1;
            default: ;
        endcase
        return r & m;
    endfunction

    function automatic bit all_done();
        bit d = 1'b1;
        for (int i = 0; i < int'(NCFG); i++) d &= sw_done[i];
        return d;
    endfunction

    // Main 52-bit radix-16 instance
    logic              rst_n, in_valid, in_ready, sgn, flush, out_valid, out_ready, busy;
    logic [MW-1:0]     a, b;
    logic [2*MW-1:0]   prod;
    logic [127:0]      exp_q [$];
    int unsigned       acc_cyc_q [$];

    booth_mul_iter #(.WIDTH(MW), .RADIX_LOG2(4)) u_dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .in_valid_i (in_valid),
        .in_ready_o (in_ready),
        .a_i        (a),
        .b_i        (b),
        .signed_i   (sgn),
        .flush_i    (flush),
        .out_valid_o(out_valid),
        .out_ready_i(out_ready),
        .product_o  (prod),
        .busy_o     (busy)
    );

    // Returns at the negedge of the cycle after acceptance (PRECOMP)
    task automatic drive_op(input logic [MW-1:0] ta, input logic [MW-1:0] tb, input logic ts);
        int n = 0;
        @(negedge clk);
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) check_eq("drive_ready_timeout", 128'(in_ready), 128'(1));
        a        = ta;
        b        = tb;
        sgn      = ts;
        in_valid = 1'b1;
        exp_q.push_back(model(64'(ta), 64'(tb), MW, ts));
        acc_cyc_q.push_back(cyc);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_valid(output int unsigned lat, output int unsigned bc);
        int n = 0;
        bc = 0;
        while (!out_valid && n < 200) begin
            if (busy) bc++;
            @(negedge clk);
            n++;
        end
        if (!out_valid) check_eq("valid_timeout", 128'(out_valid), 128'(1));
        lat = cyc - acc_cyc_q[0];
    endtask

    task automatic pop_check(input string tag);
        check_eq(tag, 128'(prod), exp_q.pop_front());
        void'(acc_cyc_q.pop_front());
    endtask

    initial begin : p_main
        int unsigned  lat, bc, t0, n;
        logic [63:0]  r1, r2;
        logic [127:0] k;
        bit           seen;
        rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; sgn = 1'b0;
        flush = 1'b0; out_ready = 1'b0;
        #3;
        check_eq("rst_in_ready", 128'(in_ready), 128'(1));
        check_eq("rst_out_valid", 128'(out_valid), 128'(0));
        check_eq("rst_busy", 128'(busy), 128'(0));
        check_eq("rst_product", 128'(prod), 128'(0));
        @(negedge clk);
        rst_n = 1'b1;

        // -1 * -1 signed: latency and busy length
        out_ready = 1'b1;
        drive_op('1, '1, 1'b1);
        wait_valid(lat, bc);
        check_eq("t1_latency", 128'(lat), 128'(MLAT));
        check_eq("t1_busy_cycles", 128'(bc), 128'(MND + 1));
        check_eq("t1_product_one", 128'(prod), 128'(1));
        pop_check("t1_product");

        // max unsigned, then same operands signed back to back
        drive_op('1, '1, 1'b0);
        wait_valid(lat, bc);
        check_eq("t2_latency", 128'(lat), 128'(MLAT));
        k = (128'(1) << 104) - (128'(1) << 53) + 128'(1);
        check_eq("t2_product_const", 128'(prod), k);
        t0 = acc_cyc_q[0];
        pop_check("t2_product");
        drive_op('1, '1, 1'b1);
        check_eq("throughput", 128'(acc_cyc_q[0] - t0), 128'(MND + 3));
        wait_valid(lat, bc);
        pop_check("t3_product");

        // signed extremes
        drive_op(52'h8000000000000, 52'h8000000000000, 1'b1);
        wait_valid(lat, bc);
        check_eq("ext_minmin_const", 128'(prod), 128'(1) << 102);
        pop_check("ext_minmin");
        drive_op(52'h8000000000000, 52'h7FFFFFFFFFFFF, 1'b1);
        wait_valid(lat, bc);
        k = (128'(1) << 104) - (128'(1) << 102) + (128'(1) << 51);
        check_eq("ext_minmax_const", 128'(prod), k);
        pop_check("ext_minmax");

        // backpressure in DONE
        r1 = {$urandom(), $urandom()};
        r2 = {$urandom(), $urandom()};
        drive_op(r1[MW-1:0], r2[MW-1:0], 1'b1);
        out_ready = 1'b0;
        wait_valid(lat, bc);
        check_eq("bp_latency", 128'(lat), 128'(MLAT));
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check_eq("bp_valid_hold", 128'(out_valid), 128'(1));
            check_eq("bp_ready_low", 128'(in_ready), 128'(0));
            check_eq("bp_product_hold", 128'(prod), exp_q[0]);
        end
        out_ready = 1'b1;
        pop_check("bp_product");
        @(negedge clk);
        check_eq("bp_idle_ready", 128'(in_ready), 128'(1));
        check_eq("bp_idle_valid", 128'(out_valid), 128'(0));
        check_eq("bp_idle_product", 128'(prod), 128'(0));

        // flush in the 5th MUL cycle
        drive_op(r2[MW-1:0], r1[MW-1:0], 1'b0);
        repeat (5) @(negedge clk);
        check_eq("flush_busy_before", 128'(busy), 128'(1));
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check_eq("flush_idle_ready", 128'(in_ready), 128'(1));
        check_eq("flush_idle_busy", 128'(busy), 128'(0));
        seen = 1'b0;
        repeat (MND + 4) begin
            @(negedge clk);
            seen |= out_valid;
        end
        check_eq("flush_no_valid", 128'(seen), 128'(0));
        void'(exp_q.pop_front());
        void'(acc_cyc_q.pop_front());

        // flush wins over a simultaneous in_valid
        a = 52'd7; b = 52'd9; sgn = 1'b0;
        in_valid = 1'b1;
        flush = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        flush = 1'b0;
        check_eq("flush_prio_busy", 128'(busy), 128'(0));
        check_eq("flush_prio_ready", 128'(in_ready), 128'(1));

        drive_op(52'd3, 52'd5, 1'b0);
        wait_valid(lat, bc);
        check_eq("post_flush_15", 128'(prod), 128'(15));
        pop_check("post_flush_product");
        @(negedge clk);

        n = 0;
        while (!all_done() && n < 60000) begin
            @(negedge clk);
            n++;
        end
        check_eq("sweep_done", 128'(all_done()), 128'(1));
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    for (genvar g = 0; g < int'(NCFG); g++) begin : g_sweep
        localparam int unsigned W  = CFG_W[g];
        localparam int unsigned R  = CFG_R[g];
        localparam int unsigned ND = (W + 1 + R - 1) / R;

        logic           s_rst_n, s_in_valid, s_in_ready, s_sgn, s_flush;
        logic           s_out_valid, s_out_ready, s_busy;
        logic [W-1:0]   s_a, s_b;
        logic [2*W-1:0] s_prod;
        logic [127:0]   s_exp_q [$];
        int unsigned    s_cyc_q [$];

        booth_mul_iter #(.WIDTH(W), .RADIX_LOG2(R)) u_dut (
            .clk_i      (clk),
            .rst_ni     (s_rst_n),
            .in_valid_i (s_in_valid),
            .in_ready_o (s_in_ready),
            .a_i        (s_a),
            .b_i        (s_b),
            .signed_i   (s_sgn),
            .flush_i    (s_flush),
            .out_valid_o(s_out_valid),
            .out_ready_i(s_out_ready),
            .product_o  (s_prod),
            .busy_o     (s_busy)
        );

        initial begin : p_sweep
            logic [63:0] ra, rb;
            logic        rs;
            int unsigned ops, guard;
            bit          seen;
            s_rst_n = 1'b0; s_in_valid = 1'b0; s_a = '0; s_b = '0; s_sgn = 1'b0;
            s_flush = 1'b0; s_out_ready = 1'b0;
            ops = 0; guard = 0; seen = 1'b0;
            repeat (2) @(negedge clk);
            s_rst_n = 1'b1;
            while (ops < NOPS && guard < 20000) begin
                @(negedge clk);
                guard++;
                s_in_valid = 1'b0;
                if (s_busy && $urandom_range(0, 59) == 0) begin
                    s_rst_n = 1'b0;
                    #1;
                    check_eq("sw_rst_ready", 128'(s_in_ready), 128'(1));
                    check_eq("sw_rst_valid", 128'(s_out_valid), 128'(0));
                    check_eq("sw_rst_busy", 128'(s_busy), 128'(0));
                    check_eq("sw_rst_product", 128'(s_prod), 128'(0));
                    #1;
                    s_rst_n = 1'b1;
                    s_exp_q.delete();
                    s_cyc_q.delete();
                    seen = 1'b0;
                end else if (s_out_valid) begin
                    if (s_exp_q.size() == 0) begin
                        check_eq("sw_qsize", 128'(s_exp_q.size()), 128'(1));
                        s_out_ready = 1'b1;
                    end else begin
                        if (!seen) begin
                            seen = 1'b1;
                            check_eq("sw_latency", 128'(cyc - s_cyc_q[0]), 128'(ND + 2));
                        end
                        s_out_ready = ($urandom_range(0, 3) != 0);
                        if (s_out_ready) begin
                            check_eq("sw_product", 128'(s_prod), s_exp_q.pop_front());
                            void'(s_cyc_q.pop_front());
                            ops++;
                            seen = 1'b0;
                        end
                    end
                end else begin
                    s_out_ready = 1'($urandom_range(0, 1));
                    if (s_in_ready && s_exp_q.size() == 0) begin
                        ra = rnd_op(W);
                        rb = rnd_op(W);
                        rs = 1'($urandom_range(0, 1));
                        s_a = ra[W-1:0];
                        s_b = rb[W-1:0];
                        s_sgn = rs;
                        s_in_valid = 1'b1;
                        s_exp_q.push_back(model(ra, rb, W, rs));
                        s_cyc_q.push_back(cyc);
                    end
                end
            end
            if (ops < NOPS) check_eq("sw_timeout", 128'(ops), 128'(NOPS));
            sw_done[g] = 1'b1;
        end
    end

endmodule
